// File: rtl/fu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue_ctrl_if
// Purpose  : Bundles the request/response handshakes and the FU-side bus
//            seen by fu_issue_ctrl. The slave modport is the controller's
//            view; the master modport is the surrounding pipeline/FU view.
// Revision : 1.0  initial release
// ============================================================================
interface fu_issue_ctrl_if #(
    parameter int DBITS     = 32,
    parameter int ALUOPBITS = 4,
    parameter int TAGBITS   = 5
);
    logic                 req_valid;
    logic                 req_ready;
    logic [ALUOPBITS-1:0] req_aluop;
    logic [DBITS-1:0]     req_op1;
    logic [DBITS-1:0]     req_op2;
    logic [TAGBITS-1:0]   req_tag;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [DBITS-1:0]     resp_data;
    logic [TAGBITS-1:0]   resp_tag;
    logic                 resp_err;

    logic                 fu_wr_aluop;
    logic                 fu_wr_op1;
    logic                 fu_wr_op2;
    logic [DBITS-1:0]     fu_wr_data;
    logic                 fu_rd_op3;
    logic [2:0]           fu_csr_out;
    logic [DBITS-1:0]     fu_op3;

    modport slave (
        input  req_valid, req_aluop, req_op1, req_op2, req_tag,
        input  resp_ready, fu_csr_out, fu_op3,
        output req_ready, resp_valid, resp_data, resp_tag, resp_err,
        output fu_wr_aluop, fu_wr_op1, fu_wr_op2, fu_wr_data, fu_rd_op3
    );

    modport master (
        output req_valid, req_aluop, req_op1, req_op2, req_tag,
        output resp_ready, fu_csr_out, fu_op3,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_err,
        input  fu_wr_aluop, fu_wr_op1, fu_wr_op2, fu_wr_data, fu_rd_op3
    );
endinterface
`default_nettype wire

// File: rtl/fu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue_ctrl
// Purpose  : Offloads one ALU operation at a time to the FU stage: writes
//            opcode/op1/op2 over the shared FU bus, waits for the result
//            (with timeout), retires the FU and returns OP3 with its tag.
// Revision : 1.0  initial release
// ============================================================================
module fu_issue_ctrl #(
    parameter int DBITS          = 32,
    parameter int ALUOPBITS      = 4,
    parameter int TAGBITS        = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  wire logic      clk,
    input  wire logic      reset,
    fu_issue_ctrl_if.slave bus,
    output logic           busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_ALUOP = 3'd1,
        S_WR_OP1   = 3'd2,
        S_WR_OP2   = 3'd3,
        S_WAIT_RES = 3'd4,
        S_RD0      = 3'd5,
        S_RD1      = 3'd6,
        S_RESP     = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ALUOPBITS-1:0] r_aluop;
    logic [DBITS-1:0]     r_op1;
    logic [DBITS-1:0]     r_op2;
    logic [TAGBITS-1:0]   r_tag;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_accept;
    logic                 w_res_ready;
    logic                 w_timeout;

    assign w_accept      = bus.req_valid && (r_state == S_IDLE);
    assign w_res_ready   = bus.fu_csr_out[2];
    assign w_timeout     = (r_cnt == C_CNT_LIMIT);
    assign bus.req_ready = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode; result capture takes priority over timeout
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:     if (w_accept) w_state_next = S_WR_ALUOP;
            S_WR_ALUOP: w_state_next = S_WR_OP1;
            S_WR_OP1:   w_state_next = S_WR_OP2;
            S_WR_OP2:   w_state_next = S_WAIT_RES;
            S_WAIT_RES: begin
                if (w_res_ready)    w_state_next = S_RD0;
                else if (w_timeout) w_state_next = S_RESP;
            end
            S_RD0:      w_state_next = S_RD1;
            S_RD1:      w_state_next = S_RESP;
            S_RESP:     if (bus.resp_ready) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // FU strobes and write data, registered from the next state so each
    // strobe lines up with the state it belongs to
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.fu_wr_aluop <= 1'b0;
            bus.fu_wr_op1   <= 1'b0;
            bus.fu_wr_op2   <= 1'b0;
            bus.fu_rd_op3   <= 1'b0;
            bus.fu_wr_data  <= '0;
        end else begin
            bus.fu_wr_aluop <= (w_state_next == S_WR_ALUOP);
            bus.fu_wr_op1   <= (w_state_next == S_WR_OP1);
            bus.fu_wr_op2   <= (w_state_next == S_WR_OP2);
            bus.fu_rd_op3   <= (w_state_next == S_RD0) || (w_state_next == S_RD1);
            // Opcode write is only reached from IDLE, before r_aluop is
            // loaded, so it takes the opcode straight from the request
            case (w_state_next)
                S_WR_ALUOP: bus.fu_wr_data <= {{(DBITS-ALUOPBITS){1'b0}}, bus.req_aluop};
                S_WR_OP1:   bus.fu_wr_data <= r_op1;
                S_WR_OP2:   bus.fu_wr_data <= r_op2;
                default:    bus.fu_wr_data <= '0;
            endcase
        end
    end

    // Request latch and wait-for-result counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aluop <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_tag   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_aluop <= bus.req_aluop;
                r_op1   <= bus.req_op1;
                r_op2   <= bus.req_op2;
                r_tag   <= bus.req_tag;
            end
            if (r_state == S_WAIT_RES) r_cnt <= r_cnt + CNT_W'(1);
            else                       r_cnt <= '0;
        end
    end

    // Response capture; data/tag/err stay put until the next completion
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_tag   <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= (w_state_next == S_RESP);
            if (r_state == S_WAIT_RES) begin
                if (w_res_ready) begin
                    bus.resp_data <= bus.fu_op3;
                    bus.resp_err  <= 1'b0;
                    bus.resp_tag  <= r_tag;
                end else if (w_timeout) begin
                    bus.resp_data <= '0;
                    bus.resp_err  <= 1'b1;
                    bus.resp_tag  <= r_tag;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_issue_ctrl
// Purpose  : Self-checking bench for fu_issue_ctrl. A behavioural FU and a
//            cycle-timeline reference (derived from request acceptance and
//            the FU ready cycle) drive and check the controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_fu_issue_ctrl;
    localparam int DBITS = 32;
    localparam int ALUOPBITS = 4;
    localparam int TAGBITS = 5;
    localparam int TO = 16;
    localparam int NEVER = 1 << 30;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    fu_issue_ctrl_if #(.DBITS(DBITS), .ALUOPBITS(ALUOPBITS), .TAGBITS(TAGBITS)) bus ();

    fu_issue_ctrl #(
        .DBITS(DBITS), .ALUOPBITS(ALUOPBITS), .TAGBITS(TAGBITS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    // Behavioural FU: remembers what was written, raises ready at a chosen
    // cycle, and drops it once the controller reads the result
    int          ready_at = NEVER;
    bit          fu_done = 1'b0;
    logic [3:0]  fu_aluop = '0;
    logic [31:0] fu_a = '0;
    logic [31:0] fu_b = '0;

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign bus.fu_csr_out = {(cyc >= ready_at) && !fu_done, 2'b00};
    assign bus.fu_op3     = alu_fn(fu_aluop, fu_a, fu_b);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One transaction: lat = cycles after entering WAIT_RES before the FU
    // reports ready (beyond TO-1 means it never does); bp = extra cycles of
    // response back-pressure.
    task automatic run_txn(input logic [3:0] aluop, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [4:0] tag, input int lat, input int bp,
                           output int c0, output int done_cyc);
        bit          err;
        int          resp_rel;
        int          rel;
        bit          finished;
        logic [2:0]  exp_wr;
        bit          exp_rd;
        bit          exp_rv;
        logic [31:0] exp_wd;
        logic [31:0] exp_data;

        fu_done  = 1'b0;
        ready_at = NEVER;
        bus.req_aluop = aluop;
        bus.req_op1   = op1;
        bus.req_op2   = op2;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.req_ready; i++) step();
        check("req_ready_idle", bus.req_ready, 1);
        c0 = cyc;
        done_cyc = cyc;
        err      = (lat > TO - 1);
        resp_rel = err ? (4 + TO) : (lat + 7);
        exp_data = err ? 32'h0 : alu_fn(aluop, op1, op2);
        if (!err) ready_at = c0 + 4 + lat;
        step();
        rel = 1;
        finished = 1'b0;
        while (!finished) begin
            exp_wr = {rel == 1, rel == 2, rel == 3};
            exp_rd = !err && (rel == lat + 5 || rel == lat + 6);
            exp_rv = (rel >= resp_rel);
            exp_wd = (rel == 1) ? {28'h0, aluop} : (rel == 2) ? op1 : (rel == 3) ? op2 : 32'h0;
            check("ctrl_vec",
                  {bus.fu_wr_aluop, bus.fu_wr_op1, bus.fu_wr_op2, bus.fu_rd_op3, bus.resp_valid, bus.req_ready, busy},
                  {exp_wr, exp_rd, exp_rv, 1'b0, 1'b1});
            check("wr_data", bus.fu_wr_data, exp_wd);
            if (bus.fu_wr_aluop) fu_aluop = bus.fu_wr_data[3:0];
            if (bus.fu_wr_op1)   fu_a = bus.fu_wr_data;
            if (bus.fu_wr_op2)   fu_b = bus.fu_wr_data;
            if (bus.fu_rd_op3)   fu_done = 1'b1;
            if (exp_rv) begin
                check("resp_data", bus.resp_data, exp_data);
                check("resp_tag_err", {bus.resp_tag, bus.resp_err}, {tag, err});
            end
            // Garbage on the request side must be ignored while busy
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.req_aluop = 4'($urandom());
            bus.req_op1   = $urandom();
            bus.req_op2   = $urandom();
            bus.req_tag   = 5'($urandom());
            if (rel >= resp_rel + bp) begin
                bus.resp_ready = 1'b1;
                bus.req_valid  = 1'b0;
                step();
                bus.resp_ready = 1'b0;
                check("complete", {bus.resp_valid, bus.req_ready, busy}, 3'b010);
                done_cyc = cyc;
                finished = 1'b1;
            end else begin
                step();
                rel++;
            end
        end
    endtask

    initial begin
        int c0a, d1, c0b, d2;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_aluop  = '0;
        bus.req_op1    = '0;
        bus.req_op2    = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;
        repeat (3) step();
        check("rst_ctrl", {bus.resp_valid, bus.resp_err, bus.fu_wr_aluop, bus.fu_wr_op1,
                           bus.fu_wr_op2, bus.fu_rd_op3, busy}, 7'h0);
        check("rst_data", {bus.resp_data, bus.fu_wr_data}, 64'h0);
        reset = 1'b0;
        step();
        check("rst_req_ready", bus.req_ready, 1);

        // Basic add with 4-cycle compute
        run_txn(4'd0, 32'd5, 32'd7, 5'd3, 4, 0, c0a, d1);
        // Back-pressure for 10 cycles
        run_txn(4'd1, 32'd100, 32'd58, 5'd9, 2, 10, c0a, d1);
        // Back-to-back: wrap-around add, then 100+23
        run_txn(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd1, 1, 0, c0a, d1);
        run_txn(4'd0, 32'd100, 32'd23, 5'd2, 0, 0, c0b, d2);
        check("b2b_accept", c0b, d1);
        // Timeout: FU never raises ready
        run_txn(4'd2, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd17, 99, 1, c0a, d1);
        // Ready rises on the same cycle the counter hits the limit
        run_txn(4'd4, 32'h1234_5678, 32'h0000_FFFF, 5'd30, TO - 1, 0, c0a, d1);

        // Reset in the middle of WAIT_RES
        fu_done       = 1'b0;
        ready_at      = NEVER;
        bus.req_aluop = 4'd3;
        bus.req_op1   = 32'hA5;
        bus.req_op2   = 32'h5A;
        bus.req_tag   = 5'd7;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        repeat (6) step();
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        step();
        step();
        check("midrst_ctrl", {bus.resp_valid, bus.resp_err, bus.fu_wr_aluop, bus.fu_wr_op1,
                              bus.fu_wr_op2, bus.fu_rd_op3, busy}, 7'h0);
        check("midrst_data", {bus.resp_data, bus.fu_wr_data}, 64'h0);
        check("midrst_tag", bus.resp_tag, 0);
        reset = 1'b0;
        step();
        check("midrst_req_ready", bus.req_ready, 1);
        run_txn(4'd0, 32'd40, 32'd2, 5'd11, 3, 0, c0a, d1);

        // Randomized traffic, including timeouts and back-pressure
        for (int k = 0; k < 20; k++) begin
            run_txn(4'($urandom_range(0, 7)), $urandom(), $urandom(), 5'($urandom()),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), c0a, d1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fu_issue_ctrl.md
Name: fu_issue_ctrl

Overview:
- Decode-side controller that offloads one ALU operation at a time to the functional-unit stage and returns its result.
- Accepts a request {aluop, op1, op2, rd tag} on a valid/ready handshake.
- Serialises the request onto the FU's shared write bus (aluop, then op1, then op2), waits for the FU result-ready flag, captures OP3, retires the FU with a read strobe, and presents the result on a valid/ready response port.
- Sits in DE, directly upstream of the FU stage; drives from_DE_to_FU and consumes from_FU_to_DE.

Parameters:
- DBITS, 32, data width of operands, FU write bus and result.
- ALUOPBITS, 4, ALU opcode width.
- TAGBITS, 5, destination-register tag carried from request to response.
- TIMEOUT_CYCLES, 1024, max cycles spent in WAIT_RES before an error response is produced.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_aluop  in  ALUOPBITS  ALU opcode.
- req_op1  in  DBITS  operand 1.
- req_op2  in  DBITS  operand 2.
- req_tag  in  TAGBITS  destination tag.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_data  out  DBITS  result (OP3).
- resp_tag  out  TAGBITS  tag of the completed request.
- resp_err  out  1  response produced by timeout.
- fu_wr_aluop  out  1  FU write strobe, opcode.
- fu_wr_op1  out  1  FU write strobe, operand 1.
- fu_wr_op2  out  1  FU write strobe, operand 2.
- fu_wr_data  out  DBITS  FU shared write data.
- fu_rd_op3  out  1  FU result-read strobe.
- fu_csr_out  in  3  FU status; bit2 = result ready.
- fu_op3  in  DBITS  FU result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, synchronous active-high, overrides everything:
  - state=IDLE, all fu_* strobes 0, fu_wr_data=0.
  - resp_valid=0, resp_data=0, resp_tag=0, resp_err=0, timeout counter=0, busy=0.
  - Reset mid-operation abandons the transaction; the FU is reset by the same signal.
- State machine: IDLE, WR_ALUOP, WR_OP1, WR_OP2, WAIT_RES, RD0, RD1, RESP.
- IDLE: req_ready=1 only here.
  - On req_valid&req_ready, latch aluop/op1/op2/tag into internal regs and go to WR_ALUOP.
  - req_ready=0 in every other state.
- WR_ALUOP: fu_wr_aluop=1, fu_wr_data=zero-extended aluop; go to WR_OP1.
- WR_OP1: fu_wr_op1=1, fu_wr_data=op1; go to WR_OP2.
- WR_OP2: fu_wr_op2=1, fu_wr_data=op2; go to WAIT_RES.
- Strobes are registered outputs, exactly one cycle each, never overlapping. fu_wr_data=0 when no write strobe is high.
- WAIT_RES: counter increments each cycle.
  - If fu_csr_out[2]=1: capture resp_data<=fu_op3, resp_err<=0; go to RD0.
  - Else if counter reaches TIMEOUT_CYCLES-1: resp_data<=0, resp_err<=1; go to RESP without a read strobe.
  - Result capture wins if both occur in the same cycle.
- RD0, RD1: fu_rd_op3=1 in both cycles.
  - Two cycles cover the FU's one-cycle lag between seeing ready and entering its result state.
  - A second strobe seen by an idle FU is harmless.
  - RD1 goes to RESP.
- RESP: resp_valid=1, resp_tag=latched tag; hold data/tag/err stable until resp_ready. On resp_ready go to IDLE, resp_valid<=0.
- Latency, no back-pressure: request accepted cycle 0 → write strobes cycles 1,2,3 → WAIT_RES from cycle 4.
  - If ready is seen in cycle N: strobes in N+1, N+2; resp_valid from N+3.
- No new FU writes are issued while a transaction is outstanding. req_valid is ignored outside IDLE.
- Counter clears on entry to WAIT_RES. resp_err persists until the next response.

Test Plan:
- Reset: assert reset 2 cycles mid-WAIT_RES → all outputs 0, req_ready=1 next cycle; new request completes normally.
- Basic op: FU model computes aluop=0 as add, 4-cycle compute; req op1=5, op2=7, tag=3.
  - Required: strobes on cycles 1,2,3 with data 0,5,7.
  - fu_rd_op3 high exactly 2 cycles; resp_data=12, resp_tag=3, resp_err=0.
- Back-pressure: resp_ready held 0 for 10 cycles → resp_valid, resp_data, resp_tag stable; req_ready=0 throughout; completion on the cycle resp_ready=1.
- Back-to-back: two requests (op1=0xFFFFFFFF, op2=1 → 0x00000000; op1=100, op2=23 → 123), resp_ready=1 always.
  - Second accepted the cycle after the first response.
  - No write strobe before the first read strobe.
- Timeout: TIMEOUT_CYCLES=16, FU never raises bit2 → resp_valid with resp_err=1, resp_data=0 on cycle 20 after acceptance; fu_rd_op3 never asserted.
- Simultaneous: bit2 rises on the same cycle the counter hits the limit → resp_err=0, resp_data=fu_op3.
